// File: rtl/methane_mmio_pkg.sv
// Shared MMIO constants and helpers for the data-memory responder.
package methane_mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF0000;
  localparam logic [15:0] MMIO_PAGE = 16'hFFFF;

  // Byte offsets inside the MMIO window; only addr[3:2] is decoded.
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLE  = 4'h8;

  // STATUS word bit positions.
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 8;

  // Logical value <-> bus byte order (logical byte 0 lives in bits [31:24]).
  function automatic logic [31:0] byteswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte-wide circular TX FIFO with a count register and sticky overflow flag.
module tx_fifo #(
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [7:0]                  push_data,
  input  logic                        pop,
  output logic [7:0]                  head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(TX_DEPTH):0]   count,
  output logic                        overflow
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(TX_DEPTH);

  logic [7:0]    mem_q [TX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Outputs depend only on state registers, so they move only at clock edges.
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign head    = empty ? 8'h00 : mem_q[rd_ptr];
  // A pop frees the slot in time for a push in the same cycle when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr] <= push_data;
  end

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !do_push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM plus MMIO window (TX FIFO, STATUS, CYCLE).
module dmem_responder
  import methane_mmio_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  data_we,
  output logic [31:0] dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]       ram [2**ADDR_W];
  logic              is_mmio;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        mmio_off;
  logic              we_any;
  logic              we_q;
  logic              push;
  logic              pop;
  logic [31:0]       cycle_q;
  logic [31:0]       status_word;
  logic [31:0]       rd_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_overflow;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        fifo_head;
  logic              unused_addr_bits;

  assign is_mmio          = (addr[31:16] == MMIO_PAGE);
  assign word_idx         = addr[ADDR_W+1:2];
  assign mmio_off         = {addr[3:2], 2'b00};
  assign we_any           = |data_we;
  assign unused_addr_bits = ^addr;

  // Only the first cycle of a held write burst may push.
  assign push     = is_mmio && (mmio_off == OFF_TXDATA) && data_we[0] && !we_q;
  assign pop      = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;

  tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (din[31:24]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_overflow)
  );

  // RAM holds logical words; bus lane k lands in logical byte k. Not reset.
  always_ff @(posedge clk) begin
    if (!is_mmio) begin
      for (int k = 0; k < 4; k++) begin
        if (data_we[k]) ram[word_idx][8*k +: 8] <= din[31-8*k -: 8];
      end
    end
  end

  // STATUS is assembled from current FIFO state (pre-edge view).
  always_comb begin
    status_word                       = '0;
    status_word[ST_FULL]              = fifo_full;
    status_word[ST_EMPTY]             = fifo_empty;
    status_word[ST_OVERFLOW]          = fifo_overflow;
    status_word[ST_COUNT_LSB +: CW]   = fifo_count;
  end

  // Read source select; RAM read is read-first relative to a same-cycle write.
  always_comb begin
    rd_word = '0;
    if (is_mmio) begin
      case (mmio_off)
        OFF_STATUS: rd_word = status_word;
        OFF_CYCLE:  rd_word = cycle_q;
        default:    rd_word = '0;
      endcase
    end else begin
      rd_word = ram[word_idx];
    end
  end

  // Registered read data in bus byte order.
  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= byteswap32(rd_word);
  end

  // Free-running cycle counter and write-burst edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      we_q    <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      we_q    <= we_any;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a queue/array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  data_we;
  logic [31:0] dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(12), .TX_DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .din      (din),
    .data_we  (data_we),
    .dout     (dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_ram  [int];
  logic [3:0]  m_mask [int];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  logic [31:0] m_cycle;
  bit          m_we_q;
  logic [31:0] exp_dout;
  bit          exp_known;

  function automatic logic [31:0] swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [7:0] exp_head();
    return (m_q.size() > 0) ? m_q[0] : 8'h00;
  endfunction

  // Drive one cycle of inputs, predict its effects, advance past the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                      input logic r, input logic rs);
    logic [31:0] v;
    logic [31:0] t;
    bit mmio;
    int idx;
    int sz;
    addr = a; din = d; data_we = w; tx_ready = r; rst = rs;
    mmio = (a[31:16] == 16'hFFFF);
    idx  = int'(a[13:2]);
    sz   = m_q.size();
    exp_known = 1'b1;
    v = 32'h0;
    if (mmio) begin
      case (a[3:2])
        2'd1: v = 32'(sz * 256 + (m_ovf ? 4 : 0) + (sz == 0 ? 2 : 0) + (sz == 16 ? 1 : 0));
        2'd2: v = m_cycle;
        default: v = 32'h0;
      endcase
    end else if (m_mask.exists(idx) && m_mask[idx] == 4'hF) begin
      v = m_ram[idx];
    end else begin
      exp_known = 1'b0;
    end
    exp_dout = rs ? 32'h0 : swap(v);
    if (rs) exp_known = 1'b1;
    if (!mmio && w != 4'h0) begin
      if (!m_ram.exists(idx)) begin m_ram[idx] = 32'h0; m_mask[idx] = 4'h0; end
      t = m_ram[idx];
      for (int k = 0; k < 4; k++) if (w[k]) t[8*k +: 8] = d[31-8*k -: 8];
      m_ram[idx]  = t;
      m_mask[idx] = m_mask[idx] | w;
    end
    if (rs) begin
      m_q.delete(); m_ovf = 1'b0; m_cycle = 32'h0; m_we_q = 1'b0;
    end else begin
      if (sz > 0 && r) void'(m_q.pop_front());
      if (mmio && a[3:2] == 2'd0 && w[0] && !m_we_q) begin
        if (m_q.size() == 16) m_ovf = 1'b1;
        else m_q.push_back(d[31:24]);
      end
      m_we_q  = (w != 4'h0);
      m_cycle = m_cycle + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want %h", dout, 32'h0); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    step(32'hFFFF0004, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h02000000) begin n_fail++; $display("FAIL reset_status: got %h want %h", dout, 32'h02000000); end
  endtask

  task automatic test_lane_writes();
    logic [31:0] a;
    step(32'h10, 32'hAABBCCDD, 4'b1111, 1'b0, 1'b0);
    step(32'h10, 32'h11000000, 4'b0001, 1'b0, 1'b0);
    step(32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h11BBCCDD) begin n_fail++; $display("FAIL lane_sb: got %h want %h", dout, 32'h11BBCCDD); end
    for (int i = 0; i < 16; i++)
      step(32'h400 + 32'(4*i) + 32'($urandom_range(0, 3)), $urandom, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++)
      step(32'h400 + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 15)), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      a = 32'h400 + 32'(4*i) + 32'($urandom_range(0, 3));
      step(a, 32'h0, 4'h0, 1'b0, 1'b0);
      n_tests++;
      if (!exp_known || dout !== exp_dout) begin
        n_fail++; $display("FAIL lane_random[%0d]: got %h want %h", i, dout, exp_dout);
      end
    end
  endtask

  task automatic test_read_first();
    step(32'h20, 32'h0, 4'hF, 1'b0, 1'b0);
    step(32'h20, 32'h12345678, 4'hF, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL read_first_old: got %h want %h", dout, 32'h0); end
    step(32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h12345678) begin n_fail++; $display("FAIL read_first_new: got %h want %h", dout, 32'h12345678); end
  endtask

  task automatic test_edge_detect();
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) step(32'hFFFF0000, 32'h41000000, 4'b0001, 1'b0, 1'b0);
    step(32'hFFFF0004, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h00010000) begin n_fail++; $display("FAIL edge_status: got %h want %h", dout, 32'h00010000); end
    n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL edge_valid: got %b want 1", tx_valid); end
    n_tests++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL edge_data: got %h want 41", tx_data); end
    step(32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL edge_drain: got %b want 0", tx_valid); end
  endtask

  task automatic test_full_overflow();
    logic [7:0] want;
    for (int i = 0; i < 17; i++) begin
      step(32'hFFFF0000, {8'(8'hA0 + i), 24'h0}, 4'b0001, 1'b0, 1'b0);
      step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    end
    step(32'hFFFF0004, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h05100000 || dout !== exp_dout) begin n_fail++; $display("FAIL full_status: got %h want %h", dout, 32'h05100000); end
    step(32'hFFFF0000, 32'hEE000000, 4'b0001, 1'b1, 1'b0);
    step(32'hFFFF0004, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h05100000) begin n_fail++; $display("FAIL full_pushpop_status: got %h want %h", dout, 32'h05100000); end
    for (int i = 0; i < 16; i++) begin
      want = (i < 15) ? 8'(8'hA1 + i) : 8'hEE;
      n_tests++;
      if (tx_valid !== 1'b1 || tx_data !== want || want !== exp_head()) begin
        n_fail++; $display("FAIL drain[%0d]: got v=%b d=%h want %h", i, tx_valid, tx_data, want);
      end
      step(32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    end
    step(32'hFFFF0004, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h06000000) begin n_fail++; $display("FAIL drained_status: got %h want %h", dout, 32'h06000000); end
  endtask

  task automatic test_back_pressure();
    logic [3:0]  plan_we [$];
    logic [31:0] plan_d  [$];
    logic [7:0]  got [$];
    logic        pv;
    logic [7:0]  pd;
    logic        r;
    int          len;
    for (int b = 1; b <= 8; b++) begin
      len = $urandom_range(1, 3);
      repeat (len) begin plan_we.push_back(4'b0001); plan_d.push_back({8'(b), 24'h0}); end
      len = $urandom_range(1, 2);
      repeat (len) begin plan_we.push_back(4'h0); plan_d.push_back(32'h0); end
    end
    for (int c = 0; c < 300; c++) begin
      if (c >= plan_we.size() && m_q.size() == 0 && tx_valid === 1'b0) break;
      pv = tx_valid; pd = tx_data; r = 1'($urandom_range(0, 1));
      if (pv === 1'b1 && r) got.push_back(pd);
      if (c < plan_we.size()) step(32'hFFFF0000, plan_d[c], plan_we[c], r, 1'b0);
      else step(32'h0, 32'h0, 4'h0, r, 1'b0);
      if (pv === 1'b1 && !r) begin
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== pd) begin
          n_fail++; $display("FAIL bp_stable: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, pd);
        end
      end
      n_tests++;
      if (tx_valid !== (m_q.size() != 0) || tx_data !== exp_head()) begin
        n_fail++; $display("FAIL bp_head: got v=%b d=%h want v=%b d=%h", tx_valid, tx_data, m_q.size() != 0, exp_head());
      end
    end
    n_tests++;
    if (got.size() != 8) begin
      n_fail++; $display("FAIL bp_count: got %0d bytes want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) if (got[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      step(32'hFFFF0000, {8'(8'h60 + i), 24'h0}, 4'b0001, 1'b0, 1'b0);
      step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    end
    step(32'h30, 32'hCAFEBABE, 4'hF, 1'b0, 1'b1);
    n_tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_tx: got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
    n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dout: got %h want %h", dout, 32'h0); end
    step(32'hFFFF0008, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL cycle_restart0: got %h want %h", dout, 32'h0); end
    step(32'hFFFF0008, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h01000000) begin n_fail++; $display("FAIL cycle_restart1: got %h want %h", dout, 32'h01000000); end
    step(32'hFFFF0004, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h02000000) begin n_fail++; $display("FAIL rst_mid_status: got %h want %h", dout, 32'h02000000); end
    step(32'h30, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'hCAFEBABE) begin n_fail++; $display("FAIL rst_ram_commit: got %h want %h", dout, 32'hCAFEBABE); end
    repeat (7) step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    step(32'hFFFF0008, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== exp_dout) begin n_fail++; $display("FAIL cycle_model: got %h want %h", dout, exp_dout); end
  endtask

  task automatic test_mmio_misc();
    step(32'h0, 32'h13579BDF, 4'hF, 1'b0, 1'b0);
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    step(32'hFFFF000C, 32'h77000000, 4'hF, 1'b0, 1'b0);
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    step(32'hFFFF0000, 32'h55000000, 4'b1110, 1'b0, 1'b0);
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mmio_no_push: got %b want 0", tx_valid); end
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    step(32'hFFFF0000, 32'h5A123456, 4'hF, 1'b0, 1'b0);
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin n_fail++; $display("FAIL mmio_push: got v=%b d=%h want v=1 d=5a", tx_valid, tx_data); end
    step(32'hFFFF0000, 32'h0, 4'h0, 1'b1, 1'b0);
    n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", dout); end
    step(32'hFFFF000C, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h0) begin n_fail++; $display("FAIL off_c_read: got %h want 0", dout); end
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    n_tests++; if (dout !== 32'h13579BDF || dout !== exp_dout) begin n_fail++; $display("FAIL ram_no_alias: got %h want %h", dout, 32'h13579BDF); end
  endtask

  initial begin
    addr = 32'h0; din = 32'h0; data_we = 4'h0; tx_ready = 1'b0; rst = 1'b1;
    m_ovf = 1'b0; m_cycle = 32'h0; m_we_q = 1'b0;
    test_reset();
    test_lane_writes();
    test_read_first();
    test_edge_detect();
    test_full_overflow();
    test_back_pressure();
    test_reset_mid();
    test_mmio_misc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data port: it receives byte addresses, bus-order write data and byte write enables from the core and returns read data one cycle later. Ordinary addresses go to a word-addressed RAM. A small memory-mapped I/O window exposes a transmit FIFO, drained through a valid/ready handshake toward the UART transmitter, plus a status word and a cycle counter. It sits between `core` and the board-level UART in the top module.

## Interface
- `ADDR_W`, 12: RAM word-address width; capacity is 2^ADDR_W words.
- `TX_DEPTH`, 16: TX FIFO entries; must be a power of two, at least 2.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `addr` in 32: byte address from core.
- `din` in 32: write data, bus byte order (logical byte 0 in bits [31:24]).
- `data_we` in 4: byte-lane write enables; bit k selects bus bits [31-8k:24-8k].
- `dout` out 32: registered read data, bus byte order.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: consumer accepts `tx_data` this cycle.

## Operation
- **Decode.**
  - `addr[31:16]==16'hFFFF` selects MMIO; anything else selects RAM.
  - RAM word index is `addr[ADDR_W+1:2]`.
  - `addr[1:0]` is ignored everywhere; there is no lane shifting.
- **RAM write.**
  - Every cycle with `data_we!=0`, each enabled lane k writes the corresponding bus byte into byte k of the word.
  - Writes are idempotent, so the core's multi-cycle hold of `data_we` is harmless.
- **RAM read.**
  - Reads happen every cycle, read-first: a same-cycle write to the same word returns the old data.
  - RAM contents are not cleared by reset.
- **Bus byte order on `dout`.**
  - A logical value v is presented as `{v[7:0],v[15:8],v[23:16],v[31:24]}` on all reads, RAM and MMIO alike.
- **MMIO map.** Offsets are `addr[3:2]`.
  - 0x0 TXDATA.
    - Write: enqueue bus bits [31:24] when `data_we[0]`.
    - Read returns 0.
  - 0x4 STATUS, read-only:
    - bit0: full.
    - bit1: empty.
    - bit2: sticky overflow.
    - bits[8+log2(TX_DEPTH):8]: entry count.
  - 0x8 CYCLE: read-only free-running 32-bit counter; wraps 0xFFFFFFFF→0.
  - 0xC: reads 0; writes ignored.
- **Write-burst edge detect.** The core holds `data_we` asserted for several cycles, so MMIO side effects fire only on the first cycle of a burst.
  - Register `we_q = |data_we`.
  - A push happens only when `|data_we && !we_q`.
- **TX FIFO.** Circular buffer with head/tail pointers of log2(TX_DEPTH) bits plus a count register.
  - Pop on `tx_valid && tx_ready`.
  - Push when full and no pop in the same cycle: byte dropped, overflow set. Overflow clears only on reset.
  - Push and pop in the same cycle:
    - When full, both succeed and count is unchanged.
    - When empty, only the push happens, because `tx_valid` is 0.
  - Pointers wrap modulo TX_DEPTH.

## Timing
- **Reset values.** `dout`=0, `tx_valid`=0, `tx_data`=0, count=0, pointers=0, overflow=0, CYCLE=0, `we_q`=0.
- **Read latency.** Address presented in cycle N → `dout` valid after edge N+1. This matches the core's extra load-wait cycle.
- **STATUS/CYCLE read latency.** Reads sample the value at edge N, so a push at edge N is not yet visible to a read issued in cycle N.
- **TX pop.** `tx_data`/`tx_valid` are registered views of the FIFO head and update on the edge after a push or pop.
- **TX handshake.** `tx_valid` never drops without a pop; `tx_data` is stable while `tx_valid && !tx_ready`.
- **Reset mid-operation.** Reset asserted with a pending write or full FIFO: all queued bytes are discarded and `tx_valid` is 0 on the next edge. A RAM write in the reset cycle still commits.

## Structure
- Package `methane_mmio_pkg` holds:
  - MMIO base 32'hFFFF0000.
  - Offset constants for TXDATA, STATUS and CYCLE.
  - STATUS bit-position localparams.
  - A `byteswap32` function.
- One sub-module, `tx_fifo`, parameterised by TX_DEPTH:
  - Ports: push, push_data, pop, head, full, empty, count, overflow.
- Decode, RAM, edge detect and the counter stay in `dmem_responder`.

## Test plan
- **Lane writes, SB:** write word 0x10 with `din`=0xAABBCCDD and `data_we`=4'b1111, then `data_we`=4'b0001 with `din`=0x11000000 → next read of 0x10 gives `dout`=0x11BBCCDD.
- **Read-first:** in one cycle, write 0x12345678 to 0x20 (previously 0) while reading 0x20 → `dout`=0 after that edge, 0x12345678 on the following read.
- **Edge detect:** hold `data_we`=4'b0001 at 0xFFFF0000 for 3 cycles with `din`=0x41000000 → exactly one entry, STATUS count=1, `tx_data`=0x41, `tx_valid`=1.
- **Full/overflow:** 17 separate bursts with `tx_ready`=0 → STATUS full=1, count=16, overflow=1. A push+pop cycle when full keeps count=16. Draining 16 bytes yields them in order and empty=1.
- **Backpressure stability:** toggle `tx_ready` randomly while pushing 0x01..0x08 → `tx_data` is stable whenever valid && !ready; the receiver gets 0x01..0x08 in order.
- **Reset mid-stream:** 5 bytes queued, assert `rst` for 1 cycle → `tx_valid`=0, STATUS reads 0x00000002 logical (empty, `dout`=0x02000000), CYCLE restarts from 0.
